// File: rtl/mmio_bram_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_bram_responder
// Purpose  : Memory-port responder backed by an on-chip word-addressed RAM.
//            It serves one request at a time with a fixed, programmable
//            latency. It returns read-first data, or an access fault for
//            addresses outside its window.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_bram_responder #(
    parameter int              XLEN               = 32,
    parameter logic [XLEN-1:0] BASE_ADDR          = 32'h8000_0000,
    parameter int              DEPTH              = 4096,
    parameter int              LATENCY            = 1,
    parameter logic [1:0]      ERRTY_ACCESS_FAULT = 2'd1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [XLEN-1:0]     i_req_addr,
    input  logic                i_req_wen,
    input  logic [XLEN-1:0]     i_req_wdata,
    input  logic [XLEN/8-1:0]   i_req_wmask,
    output logic                o_resp_valid,
    output logic [XLEN-1:0]     o_resp_rdata,
    output logic                o_resp_error,
    output logic [1:0]          o_resp_errty
);

    localparam int c_LANES = XLEN / 8;
    localparam int c_AW    = $clog2(DEPTH);
    // One extra bit so a window ending at the top of the address space does not wrap
    localparam logic [XLEN:0] c_WIN_LAST = {1'b0, BASE_ADDR}
                                         + ((XLEN+1)'(DEPTH) << 2)
                                         - (XLEN+1)'(1);
    // WAIT counts down from LATENCY-2; unused when LATENCY is 1
    localparam logic [2:0] c_CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_next;
    logic              w_ready;
    logic              w_accept;
    logic              w_in_window;
    logic              w_mem_we;
    logic [XLEN-1:0]   w_offset;
    logic [c_AW-1:0]   w_index;
    logic [XLEN-1:0]   r_mem [DEPTH];
    logic [XLEN-1:0]   r_rdata;
    logic              r_error;
    logic [1:0]        r_errty;

    // An address below the base is a fault even if the subtraction would wrap
    assign w_in_window = (i_req_addr >= BASE_ADDR) && ({1'b0, i_req_addr} <= c_WIN_LAST);
    assign w_offset    = i_req_addr - BASE_ADDR;
    assign w_index     = c_AW'(w_offset >> 2);
    assign w_accept    = i_req_valid & w_ready & ~reset;
    assign w_mem_we    = w_accept & w_in_window & i_req_wen;

    assign o_req_ready  = w_ready;
    assign o_resp_rdata = r_rdata;
    assign o_resp_error = r_error;
    assign o_resp_errty = r_errty;

    // Byte-lane masked write; the array is intentionally left out of reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_LANES; b++) begin
                if (i_req_wmask[b]) begin
                    r_mem[w_index][8*b +: 8] <= i_req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Capture the response on acceptance (old word, read-first) and hold it until presented
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_error <= 1'b0;
            r_errty <= 2'd0;
        end else if (w_accept) begin
            r_rdata <= w_in_window ? r_mem[w_index] : '0;
            r_error <= ~w_in_window;
            r_errty <= w_in_window ? 2'd0 : ERRTY_ACCESS_FAULT;
        end
    end

    // State and latency-counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state, ready and response-valid decode
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ready      = 1'b0;
        o_resp_valid = 1'b0;
        case (r_state)
            S_IDLE, S_RESP: begin
                w_ready      = 1'b1;
                o_resp_valid = (r_state == S_RESP);
                if (i_req_valid) begin
                    if (LATENCY == 1) begin
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = c_CNT_LOAD;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_bram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_bram_responder
// Purpose  : Self-checking bench for mmio_bram_responder. Three instances
//            (LATENCY 1, 3 and 4) are compared every cycle against a
//            word-array/timing model. Directed literal expectations are
//            followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_bram_responder;

    localparam int          NI    = 3;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b1;
    logic [NI-1:0]        req_valid;
    logic [NI-1:0]        req_ready;
    logic [NI-1:0]        req_wen;
    logic [NI-1:0]        resp_valid;
    logic [NI-1:0]        resp_error;
    logic [NI-1:0][31:0]  req_addr;
    logic [NI-1:0][31:0]  req_wdata;
    logic [NI-1:0][31:0]  resp_rdata;
    logic [NI-1:0][3:0]   req_wmask;
    logic [NI-1:0][1:0]   resp_errty;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            mmio_bram_responder #(
                .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))
            ) u_dut (
                .clk          (clk),
                .reset        (reset),
                .i_req_valid  (req_valid[g]),
                .o_req_ready  (req_ready[g]),
                .i_req_addr   (req_addr[g]),
                .i_req_wen    (req_wen[g]),
                .i_req_wdata  (req_wdata[g]),
                .i_req_wmask  (req_wmask[g]),
                .o_resp_valid (resp_valid[g]),
                .o_resp_rdata (resp_rdata[g]),
                .o_resp_error (resp_error[g]),
                .o_resp_errty (resp_errty[g])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit live     = 1'b0;

    // Reference model: word array plus one outstanding response per instance
    bit [31:0] mem [NI][DEPTH];
    int        next_ok   [NI];
    bit        pend      [NI];
    int        pend_due  [NI];
    bit [31:0] pend_rdata[NI];
    bit        pend_err  [NI];
    bit        after_rst [NI];

    // Log of what the DUTs actually did, used by the literal checks
    int        resp_cnt [NI];
    bit [31:0] rlog_d   [NI][64];
    bit        rlog_e   [NI][64];
    bit [1:0]  rlog_t   [NI][64];
    int        rlog_c   [NI][64];
    int        acc_cnt  [NI];
    int        acc_edge [NI][64];

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, i, cyc, act, exp);
        end
    endtask

    // Model one accepted request at the upcoming edge
    task automatic model_access(int i, int edge_n);
        bit        inwin;
        int        idx;
        bit [31:0] a;
        bit [31:0] old;
        a     = req_addr[i];
        inwin = (a >= BASE) && ({1'b0, a} <= ({1'b0, BASE} + 33'(4 * DEPTH) - 33'd1));
        old   = 32'd0;
        if (inwin) begin
            idx = int'((a - BASE) >> 2);
            old = mem[i][idx];
            if (req_wen[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_wmask[i][b]) mem[i][idx][8*b +: 8] = req_wdata[i][8*b +: 8];
                end
            end
        end
        pend[i]       = 1'b1;
        pend_due[i]   = edge_n + lat_of(i) - 1;
        pend_rdata[i] = old;
        pend_err[i]   = ~inwin;
        next_ok[i]    = edge_n + lat_of(i);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: negedge after edge number cyc; then model edge cyc+1
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (live) begin
                bit exp_ready;
                bit exp_valid;
                exp_ready = (cyc + 1 >= next_ok[i]);
                exp_valid = pend[i] && (pend_due[i] == cyc);
                chk("req_ready", i, 32'(req_ready[i]), 32'(exp_ready));
                chk("resp_valid", i, 32'(resp_valid[i]), 32'(exp_valid));
                if (exp_valid) begin
                    chk("resp_rdata", i, resp_rdata[i], pend_rdata[i]);
                    chk("resp_error", i, 32'(resp_error[i]), 32'(pend_err[i]));
                    chk("resp_errty", i, 32'(resp_errty[i]), pend_err[i] ? 32'd1 : 32'd0);
                    pend[i] = 1'b0;
                end
                if (after_rst[i]) begin
                    chk("rst_rdata", i, resp_rdata[i], 32'd0);
                    chk("rst_error", i, 32'(resp_error[i]), 32'd0);
                    chk("rst_errty", i, 32'(resp_errty[i]), 32'd0);
                    after_rst[i] = 1'b0;
                end
            end
            if (resp_valid[i] === 1'b1) begin
                rlog_d[i][resp_cnt[i] % 64] = resp_rdata[i];
                rlog_e[i][resp_cnt[i] % 64] = resp_error[i];
                rlog_t[i][resp_cnt[i] % 64] = resp_errty[i];
                rlog_c[i][resp_cnt[i] % 64] = cyc;
                resp_cnt[i]++;
            end
            if (req_valid[i] && (req_ready[i] === 1'b1) && !reset) begin
                acc_edge[i][acc_cnt[i] % 64] = cyc + 1;
                acc_cnt[i]++;
            end
            if (reset) begin
                pend[i]      = 1'b0;
                next_ok[i]   = cyc + 2;
                after_rst[i] = 1'b1;
            end else if (live && req_valid[i] && (cyc + 1 >= next_ok[i])) begin
                model_access(i, cyc + 1);
            end
        end
        if (reset) live = 1'b1;
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request and hold it until accepted; returns just after the accept edge
    task automatic issue(int i, logic [31:0] a, logic w, logic [31:0] d, logic [3:0] m);
        bit acc;
        int t;
        acc          = 1'b0;
        t            = 0;
        req_addr[i]  = a;
        req_wen[i]   = w;
        req_wdata[i] = d;
        req_wmask[i] = m;
        req_valid[i] = 1'b1;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = (req_ready[i] === 1'b1);
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout inst%0d: got no accept expected accept", i);
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_resp(int i, int target);
        int t;
        t = 0;
        while (resp_cnt[i] < target && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("resp_count", i, 32'(resp_cnt[i]), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n0;
        int a0;
        req_valid = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;

        // Reset and idle
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("idle_ready", i, 32'(req_ready[i]), 32'd1);
            chk("idle_valid", i, 32'(resp_valid[i]), 32'd0);
            chk("idle_rdata", i, resp_rdata[i], 32'd0);
        end
        @(posedge clk);
        #1;

        // LATENCY=1: write, read, partial-mask write, read, faults, recheck
        n0 = resp_cnt[0];
        issue(0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
        issue(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0);
        issue(0, 32'h8000_0010, 1'b1, 32'h1122_3344, 4'b0101);
        issue(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0);
        issue(0, 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0);
        issue(0, 32'h8000_4000, 1'b0, 32'h0, 4'h0);
        issue(0, 32'h8000_4000, 1'b1, 32'h1234_5678, 4'hF);
        issue(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
        issue(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0);
        wait_resp(0, n0 + 9);
        chk("wr_old",      0, rlog_d[0][(n0+0)%64], 32'h0000_0000);
        chk("rd_full",     0, rlog_d[0][(n0+1)%64], 32'hDEAD_BEEF);
        chk("rd_full_err", 0, 32'(rlog_e[0][(n0+1)%64]), 32'd0);
        chk("pm_old",      0, rlog_d[0][(n0+2)%64], 32'hDEAD_BEEF);
        chk("rd_merged",   0, rlog_d[0][(n0+3)%64], 32'hDE22_BE44);
        chk("lo_err",      0, 32'(rlog_e[0][(n0+4)%64]), 32'd1);
        chk("lo_errty",    0, 32'(rlog_t[0][(n0+4)%64]), 32'd1);
        chk("lo_rdata",    0, rlog_d[0][(n0+4)%64], 32'd0);
        chk("hi_err",      0, 32'(rlog_e[0][(n0+5)%64]), 32'd1);
        chk("hi_errty",    0, 32'(rlog_t[0][(n0+5)%64]), 32'd1);
        chk("hi_rdata",    0, rlog_d[0][(n0+5)%64], 32'd0);
        chk("hi_wr_err",   0, 32'(rlog_e[0][(n0+6)%64]), 32'd1);
        chk("idx0_clean",  0, rlog_d[0][(n0+7)%64], 32'd0);
        chk("rd_kept",     0, rlog_d[0][(n0+8)%64], 32'hDE22_BE44);
        chk("b2b_l1",      0, 32'(rlog_c[0][(n0+1)%64] - rlog_c[0][(n0+0)%64]), 32'd1);

        // LATENCY=3: preload four words, then four back-to-back reads
        n0 = resp_cnt[1];
        for (int k = 0; k < 4; k++) begin
            issue(1, 32'h8000_0100 + 32'(4*k), 1'b1, 32'hA0A0_0000 + 32'(k), 4'hF);
        end
        a0 = acc_cnt[1];
        for (int k = 0; k < 4; k++) begin
            issue(1, 32'h8000_0100 + 32'(4*k), 1'b0, 32'h0, 4'h0);
        end
        wait_resp(1, n0 + 8);
        for (int k = 0; k < 4; k++) begin
            chk("b2b_data", 1, rlog_d[1][(n0+4+k)%64], 32'hA0A0_0000 + 32'(k));
            chk("b2b_lat", 1, 32'(rlog_c[1][(n0+4+k)%64] - acc_edge[1][(a0+k)%64]), 32'd2);
            if (k > 0) begin
                chk("b2b_spacing", 1, 32'(acc_edge[1][(a0+k)%64] - acc_edge[1][(a0+k-1)%64]), 32'd3);
            end
        end

        // LATENCY=4: reset while the write is in WAIT drops the response, not the write
        n0 = resp_cnt[2];
        issue(2, 32'h8000_0000, 1'b1, 32'h0000_00AA, 4'hF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(8);
        chk("no_resp_after_rst", 2, 32'(resp_cnt[2]), 32'(n0));
        issue(2, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
        wait_resp(2, n0 + 1);
        chk("committed_wr", 2, rlog_d[2][n0%64], 32'h0000_00AA);

        // Randomized traffic checked every cycle by the model
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 120; n++) begin
                logic [31:0] a;
                int          sel;
                sel = $urandom_range(0, 9);
                if (sel == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
                else if (sel == 1) a = 32'h8000_4000 + 32'(4 * $urandom_range(0, 3));
                else if (sel == 2) a = 32'hFFFF_FFFC;
                else               a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
                issue(i, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_bram_responder.md
# mmio_bram_responder

Responder end of the data-side memory request/response handshake. It accepts one request at a time from the MMIO controller's memory port and serves it from an on-chip word-addressed RAM. It returns read data, or an access fault for addresses outside its window, after a fixed programmable latency. It supports back-to-back requests so the controller can chain transactions with no idle cycle.

## Interface
- XLEN, 32: data/address width in bits; byte lanes = XLEN/8.
- BASE_ADDR, 32'h8000_0000: first byte address of the window.
- DEPTH, 4096: number of XLEN-bit words; power of two.
- LATENCY, 1: cycles from acceptance edge to resp_valid; legal range 1..8.
- ERRTY_ACCESS_FAULT, 2'd1: code driven on resp_errty for an out-of-window access.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  initiator has a request; held with fields stable until accepted.
- req_ready  out  1  responder can accept this cycle.
- req_addr  in  XLEN  byte address; bits [1:0] ignored (word access).
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  XLEN  write data.
- req_wmask  in  XLEN/8  byte-lane write enables; bit i covers wdata[8i+7:8i].
- resp_valid  out  1  one-cycle pulse; response fields valid.
- resp_rdata  out  XLEN  read data (word before write for writes).
- resp_error  out  1  access fault.
- resp_errty  out  2  error type; meaningful only when resp_error=1.

## Operation
- Accept = req_valid & req_ready at a rising edge; request fields are sampled on that edge only.
- In-window test: BASE_ADDR <= req_addr <= BASE_ADDR + 4*DEPTH - 1. Word index = (req_addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
- In-window read: the array word is captured on the acceptance edge.
- In-window write: read-first behaviour.
  - The old word is captured for resp_rdata.
  - Lanes with wmask=1 are updated on the same edge; lanes with wmask=0 are preserved.
  - wmask=0 is a legal no-op write that still returns a response.
- Out-of-window access: the array is neither read nor written.
  - Response has resp_error=1, resp_errty=ERRTY_ACCESS_FAULT, resp_rdata=0.
- In-window responses drive resp_error=0 and resp_errty=0.
- States:
  - IDLE: req_ready=1. On accept, go to RESP if LATENCY=1, else WAIT with cnt=LATENCY-2.
  - WAIT: req_ready=0. When cnt=0, go to RESP; else cnt-1.
  - RESP: resp_valid=1, req_ready=1. On accept, go to RESP/WAIT exactly as from IDLE; otherwise go to IDLE.
- The captured result is held in a response register through WAIT and presented in RESP.
- A same-cycle accept in RESP overwrites that register only at the edge ending RESP, so the current response is never corrupted.
- req_valid while req_ready=0: no effect; the initiator holds the request.
- Array contents are not affected by reset. Simulation initial contents are zero.

## Timing
- Reset values: state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_error=0, resp_errty=0. req_ready=1 in the first cycle after reset deasserts.
- Request accepted at edge E: resp_valid is high in the cycle following edge E+(LATENCY-1), for exactly one cycle.
- Throughput: LATENCY=1 gives one transaction per cycle with continuous req_valid; LATENCY=N gives one per N cycles.
- A write at edge E is visible to a read accepted at edge E+1 or later. No bypass is needed, because the array has already been updated.
- Reset mid-transaction (WAIT or RESP): the pending response is discarded with no resp_valid. A write already committed at its acceptance edge stays committed.
- Address arithmetic uses XLEN-bit unsigned compares. The window may end at 2^XLEN-1 with no wrap. An address below BASE_ADDR is always a fault, even if the subtraction wraps.

## Test plan
- Reset and idle: hold reset 3 cycles, then release → req_ready=1, resp_valid=0, rdata=0, error=0.
- Write then read, LATENCY=1:
  - Write addr 8000_0010, wdata DEADBEEF, wmask F → resp_valid next cycle, rdata=0.
  - Read 8000_0010 on the following cycle → rdata=DEADBEEF, error=0.
- Partial mask: after the previous step, write wdata 11223344, wmask 0101 → response rdata=DEADBEEF. A subsequent read returns DE22BE44.
- Fault: read 7FFF_FFFC and read BASE+4*DEPTH (8000_4000 at defaults) → each gives error=1, errty=1, rdata=0, with the array unchanged.
- Back-to-back, LATENCY=3:
  - 4 consecutive reads with req_valid held high → accepts every 3rd cycle.
  - resp_valid appears in the cycle after edge E+2 for each, with data matching each address in order.
- Reset in WAIT, LATENCY=4: accept a write of 0000_00AA to 8000_0000, then assert reset 2 cycles later → no resp_valid appears. A later read of 8000_0000 returns 0000_00AA.
